// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer
//   Issue-side controller for a combinational alu. Requests are accepted into a
//   single registered issue stage that drives the alu; the alu result, flags and
//   request tag are captured into a circular response FIFO and returned in
//   request order. Error responses are counted in a saturating counter.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready                 request handshake
//   req_op, req_a, req_b, req_tag       request payload
//   alu_a, alu_b, alu_op_code           drive to alu (zero when idle)
//   alu_result, alu_flags               combinational alu return {err,ovf,neg,zero}
//   rsp_valid/rsp_ready                 response handshake
//   rsp_result, rsp_flags, rsp_tag      FIFO head (zero when empty)
//   err_clr, err_count                  clear / saturating error-response count
//   busy                                issue occupied or responses queued
module alu_op_sequencer #(
  parameter int WIDTH     = 32,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op_code,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             err_clr,
  output logic [15:0]      err_count,
  output logic             busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RSP_DEPTH);

  logic             issue_valid_q, issue_valid_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] mem_result [RSP_DEPTH];
  logic [3:0]       mem_flags  [RSP_DEPTH];
  logic [TAG_W-1:0] mem_tag    [RSP_DEPTH];

  logic push, pop, accept, err_push;

  // Full FIFO stalls issue regardless of rsp_ready: no comb path from the
  // response side back to req_ready.
  assign push      = issue_valid_q && (cnt_q != FULL_CNT);
  assign req_ready = rst_n && (!issue_valid_q || push);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign err_push  = push && alu_flags[3];

  always_comb begin
    issue_valid_d = issue_valid_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    tag_d         = tag_q;
    if (accept) begin
      issue_valid_d = 1'b1;
      op_d          = req_op;
      a_d           = req_a;
      b_d           = req_b;
      tag_d         = req_tag;
    end else if (push) begin
      issue_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear takes priority but still counts an error pushed in the same cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_push ? 16'd1 : 16'd0;
    end else if (err_push && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      tag_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      err_cnt_q     <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      tag_q         <= tag_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr_q] <= alu_result;
      mem_flags[wr_ptr_q]  <= alu_flags;
      mem_tag[wr_ptr_q]    <= tag_q;
    end
  end

  assign alu_a       = issue_valid_q ? a_q  : '0;
  assign alu_b       = issue_valid_q ? b_q  : '0;
  assign alu_op_code = issue_valid_q ? op_q : '0;

  assign rsp_result = rsp_valid ? mem_result[rd_ptr_q] : '0;
  assign rsp_flags  = rsp_valid ? mem_flags[rd_ptr_q]  : '0;
  assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr_q]    : '0;

  assign err_count = err_cnt_q;
  assign busy      = issue_valid_q || rsp_valid;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_op_code, alu_flags;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic [TW-1:0] rsp_tag;
  logic          err_clr = 1'b0;
  logic [15:0]   err_count;
  logic          busy;

  alu_op_sequencer #(.WIDTH(W), .RSP_DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .err_clr(err_clr), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench-side alu: returns {flags, result}, flags = {error, overflow, negative, zero}.
  function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic err, ovf;
    r = '0; err = 1'b0; ovf = 1'b0;
    case (op)
      4'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = a * b;
      4'd8: r = ~a;
      4'd9: if (b == 0) begin r = '1; err = 1'b1; end else r = a / b;
      default: begin r = '0; err = 1'b1; end
    endcase
    if (err) return {4'b1000, r};
    return {1'b0, ovf, r[31], (r == 32'd0), r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_op_code, alu_a, alu_b);

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int stalls = 0;
  int pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every handshaked response is compared against the head.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got tag %0h result %0h expected no response", rsp_tag, rsp_result);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        pops++;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef);
    exp_t e;
    int t;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got req_ready 0 expected 1 within 200 cycles (tag %0h)", tag);
    end else begin
      e.res = er; e.flags = ef; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    logic [35:0] m;
    m = alu_model(op, a, b);
    send(op, a, b, tag, m[31:0], m[35:32]);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_pending"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];
  int   stalls0, pops0;

  initial begin
    tbl[0]  = '{4'd0, 32'd5,        32'd7,        32'd12,       4'b0000};
    tbl[1]  = '{4'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0010};
    tbl[2]  = '{4'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0110};
    tbl[3]  = '{4'd2, 32'hF0F0,     32'h0FF0,     32'h00F0,     4'b0000};
    tbl[4]  = '{4'd4, 32'h1234,     32'h1234,     32'h0,        4'b0001};
    tbl[5]  = '{4'd3, 32'hA0000000, 32'd5,        32'hA0000005, 4'b0010};
    tbl[6]  = '{4'd7, 32'd6,        32'd7,        32'd42,       4'b0000};
    tbl[7]  = '{4'd9, 32'd100,      32'd7,        32'd14,       4'b0000};
    tbl[8]  = '{4'd9, 32'd1,        32'd0,        32'hFFFFFFFF, 4'b1000};
    tbl[9]  = '{4'hC, 32'd9,        32'd9,        32'h0,        4'b1000};
    tbl[10] = '{4'd5, 32'd1,        32'd4,        32'd16,       4'b0000};
    tbl[11] = '{4'd8, 32'd0,        32'd0,        32'hFFFFFFFF, 4'b0010};

    // Reset state
    #22;
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_alu_a", 64'(alu_a), 0);
    chk("rst_rsp_result", 64'(rsp_result), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 64'(req_ready), 1);

    // Single ADD latency: not visible after accept edge, visible after the next.
    send(4'd0, 32'd5, 32'd7, 4'd3, 32'd12, 4'b0000);
    chk("lat_rsp_valid_n", 64'(rsp_valid), 0);
    chk("lat_busy", 64'(busy), 1);
    chk("lat_alu_a", 64'(alu_a), 5);
    chk("lat_alu_b", 64'(alu_b), 7);
    @(posedge clk); #1;
    chk("lat_rsp_valid_n1", 64'(rsp_valid), 1);
    chk("lat_rsp_result", 64'(rsp_result), 12);
    chk("lat_rsp_tag", 64'(rsp_tag), 3);
    chk("lat_alu_idle", 64'(alu_a), 0);
    rsp_ready = 1'b1;
    wait_drain("lat");

    // Table vectors back-to-back
    stalls0 = stalls;
    pops0 = pops;
    for (int i = 0; i < 12; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, 4'(i), tbl[i].res, tbl[i].flags);
    chk("b2b_stalls", 64'(stalls - stalls0), 0);
    wait_drain("tbl");
    chk("tbl_pops", 64'(pops - pops0), 12);
    chk("err_count_two", 64'(err_count), 2);

    // err_clr coinciding with an error push
    send(4'd9, 32'd1, 32'd0, 4'd5, 32'hFFFFFFFF, 4'b1000);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr_with_push", 64'(err_count), 1);
    wait_drain("clr");
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr_alone", 64'(err_count), 0);

    // FIFO full: 4 queued, 5th pinned in issue, 6th waits
    rsp_ready = 1'b0;
    pops0 = pops;
    for (int i = 0; i < 5; i++) send_m(4'd0, 32'(i), 32'd100, 4'(i));
    @(negedge clk);
    chk("full_req_ready", 64'(req_ready), 0);
    chk("full_alu_a", 64'(alu_a), 4);
    chk("full_alu_b", 64'(alu_b), 100);
    chk("full_rsp_result", 64'(rsp_result), 100);
    repeat (3) @(negedge clk);
    chk("full_hold_result", 64'(rsp_result), 100);
    chk("full_hold_tag", 64'(rsp_tag), 0);
    chk("full_hold_alu_a", 64'(alu_a), 4);
    fork
      send_m(4'd0, 32'd5, 32'd100, 4'd5);
      begin
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_drain("full");
    chk("full_pops", 64'(pops - pops0), 6);

    // Reset with one issued and three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_m(4'd1, 32'd200, 32'(i), 4'(i + 8));
    chk("pre_rst_busy", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_alu_a", 64'(alu_a), 0);
    chk("mid_rst_alu_op", 64'(alu_op_code), 0);
    chk("mid_rst_req_ready", 64'(req_ready), 0);
    chk("mid_rst_rsp_tag", 64'(rsp_tag), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send_m(4'd1, 32'd50, 32'd8, 4'd9);
    wait_drain("post_rst");

    // Saturation of err_count
    for (int i = 0; i < 65534; i++) send(4'd9, 32'(i), 32'd0, 4'(i), 32'hFFFFFFFF, 4'b1000);
    wait_drain("sat");
    chk("err_count_fffe", 64'(err_count), 64'hFFFE);
    send(4'hF, 32'd1, 32'd2, 4'd1, 32'h0, 4'b1000);
    wait_drain("sat1");
    chk("err_count_ffff", 64'(err_count), 64'hFFFF);
    send(4'hC, 32'd1, 32'd2, 4'd2, 32'h0, 4'b1000);
    wait_drain("sat2");
    chk("err_count_held", 64'(err_count), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
